fifo_drain: RTL

Downstream consumer stage for the 4-entry task FIFO. Pops one entry at a time, captures the FIFO's registered data/capacity/error outputs, and presents them on a valid/ready output port. Keeps saturating counters of delivered and errored entries. Sits between the FIFO's read side and the processing core.

---
 rtl/fifo_drain.sv | 70 +++++++
 1 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: pops the task FIFO one entry at a time and presents it on a valid/ready port.
// Define FIFO_DRAIN_ERR_DROP_EN to drop entries whose error field is nonzero.
module fifo_drain #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [0:DATA_W-1] fifo_data,
  input  logic [2:0]        fifo_capacity,
  input  logic [2:0]        fifo_error,
  output logic              fifo_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_data,
  output logic [2:0]        out_capacity,
  output logic [2:0]        out_error,
  output logic              out_err_flag,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, POP, CAPT, OUT} state_t;
  state_t state, state_nx;
  logic capt_err, keep;
  assign capt_err = |fifo_error;
`ifdef FIFO_DRAIN_ERR_DROP_EN
  assign keep = !capt_err;
  assign out_err_flag = 1'b0;
`else
  assign keep = 1'b1;
  always_ff @(posedge clk)
    if (rst) out_err_flag <= 1'b0;
    else if (state == CAPT) out_err_flag <= capt_err;
`endif
  always_comb begin
    state_nx  = state;
    fifo_read = state == POP;
    out_valid = state == OUT;
    busy      = state != IDLE;
    unique case (state)
      IDLE:    state_nx = fifo_empty ? IDLE : POP;
      POP:     state_nx = CAPT;
      CAPT:    state_nx = keep ? OUT : IDLE;
      OUT:     state_nx = out_ready ? (fifo_empty ? IDLE : POP) : OUT;
      default: state_nx = IDLE;
    endcase
  end
  // Capture happens in CAPT because the FIFO's registered outputs settle one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_data     <= '0;
      out_capacity <= '0;
      out_error    <= '0;
      pass_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      state <= state_nx;
      if (state == CAPT && keep) begin
        out_data     <= fifo_data;
        out_capacity <= fifo_capacity;
        out_error    <= fifo_error;
      end
      if (state == CAPT && capt_err && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      if (state == OUT && out_ready && pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
    end
  end
endmodule
